// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder sequencer.
package serial_add_pkg;

  // Default operand/sum width
  localparam int unsigned DefaultWidth = 8;

  // Controller state encoding
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/basic_cell.sv
// Basic_Cell: single-bit full-adder cell producing sum, propagate and generate.
module basic_cell (
  input  logic x,
  input  logic y,
  input  logic c,
  output logic s,
  output logic p,
  output logic g
);

  // Plain full-adder equations
  always_comb begin
    p = x ^ y;
    g = x & y;
    s = p ^ c;
  end

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: one shared full-adder cell, LSB first, one bit
// per cycle, with start/busy/done handshake and registered results.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth,
  parameter int unsigned CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             grp_p,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] LastIdx = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               p_acc_q, p_acc_d;
  logic               cout_q, cout_d;
  logic               grp_p_q, grp_p_d;
  logic               ovf_q, ovf_d;

  logic cell_s, cell_p, cell_g;
  logic carry_next;

  basic_cell u_cell (
    .x (a_q[idx_q]),
    .y (b_q[idx_q]),
    .c (carry_q),
    .s (cell_s),
    .p (cell_p),
    .g (cell_g)
  );

  assign carry_next = cell_g | (cell_p & carry_q);

  // Next-state and datapath update for the sequencer
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    p_acc_d = p_acc_q;
    cout_d  = cout_q;
    grp_p_d = grp_p_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          acc_d   = '0;
          p_acc_d = 1'b1;
          idx_d   = '0;
          state_d = StRun;
        end else begin
          state_d = StIdle;
        end
      end
      StRun: begin
        // abort wins over the last-bit transition and leaves results untouched
        if (abort) begin
          state_d = StIdle;
        end else begin
          acc_d[idx_q] = cell_s;
          carry_d      = carry_next;
          p_acc_d      = p_acc_q & cell_p;
          if (idx_q == LastIdx) begin
            // carry_q here is the carry into the MSB
            state_d = StDone;
            sum_d   = acc_d;
            cout_d  = carry_next;
            grp_p_d = p_acc_q & cell_p;
            ovf_d   = carry_q ^ carry_next;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      p_acc_q <= 1'b0;
      cout_q  <= 1'b0;
      grp_p_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      p_acc_q <= p_acc_d;
      cout_q  <= cout_d;
      grp_p_q <= grp_p_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy  = (state_q == StRun);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign cout  = cout_q;
  assign grp_p = grp_p_q;
  assign ovf   = ovf_q;

endmodule
